// File: rtl/sfif_tag_alloc.sv
// Read-request tag allocator for the SFIF tag tracker: round-robin tag scan,
// completion-count calculation and a single-cycle issue strobe toward TX and tracker.
module sfif_tag_alloc #(
    parameter int unsigned NUM_TAGS = 32,
    parameter int unsigned RCB_DW   = 16
) (
    input  logic       clk_125,
    input  logic       rstn,
    input  logic       rd_req,
    input  logic [9:0] rd_len,
    input  logic       tx_rdy,
    input  logic       rx_st,
    input  logic       tag_available,
    output logic [4:0] tag,
    output logic [3:0] tag_cplds,
    output logic       tx_st,
    output logic       rd_ack,
    output logic       busy,
    output logic       all_busy
);

    localparam int unsigned CNT_W      = (NUM_TAGS > 2) ? $clog2(NUM_TAGS) : 1;
    localparam logic [4:0]  TAG_MASK   = 5'(NUM_TAGS - 1);
    localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(NUM_TAGS - 1);
    localparam logic [10:0] RCB        = 11'(RCB_DW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_ISSUE
    } state_t;

    state_t           r_state;
    logic             r_rx_st_p;
    logic [4:0]       r_tag;
    logic [3:0]       r_tag_cplds;
    logic             r_tx_st;
    logic             r_rd_ack;
    logic             r_busy;
    logic             r_all_busy;
    logic [CNT_W-1:0] r_sweep;

    logic [10:0]      w_len;
    logic [10:0]      w_ncpl;
    logic [3:0]       w_cplds;
    logic [4:0]       w_tag_nxt;
    logic             w_issue_nxt;

    // Completion count: ceil(L / RCB) clamped to the 4-bit tracker counter
    assign w_len     = (rd_len == 10'd0) ? 11'd1024 : {1'b0, rd_len};
    assign w_ncpl    = (w_len + RCB - 11'd1) / RCB;
    assign w_cplds   = (w_ncpl > 11'd15) ? 4'd15 : w_ncpl[3:0];
    assign w_tag_nxt = (r_tag + 5'd1) & TAG_MASK;

    // tx_st is registered, so the strobe is scheduled one edge ahead; rx_st now
    // is exactly the rx_st_p the tracker will see in the strobe cycle.
    assign w_issue_nxt = tx_rdy & ~rx_st;

    always_ff @(posedge clk_125) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_rx_st_p   <= 1'b0;
            r_tag       <= 5'd0;
            r_tag_cplds <= 4'd0;
            r_tx_st     <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_busy      <= 1'b0;
            r_all_busy  <= 1'b0;
            r_sweep     <= '0;
        end else begin
            r_rx_st_p <= rx_st;
            r_tx_st   <= 1'b0;
            r_rd_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rd_req) begin
                        r_tag_cplds <= w_cplds;
                        r_sweep     <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!r_rx_st_p) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (tag_available) begin
                        r_tx_st  <= w_issue_nxt;
                        r_rd_ack <= w_issue_nxt;
                        r_state  <= S_ISSUE;
                    end else begin
                        r_tag   <= w_tag_nxt;
                        r_state <= S_SETTLE;
                        if (r_sweep == SWEEP_LAST) begin
                            r_sweep    <= '0;
                            r_all_busy <= 1'b1;
                        end else begin
                            r_sweep <= r_sweep + CNT_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    // Strobe cycle ends here: advance to the next tag for the following request
                    if (r_tx_st) begin
                        r_tag      <= w_tag_nxt;
                        r_all_busy <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tx_st  <= w_issue_nxt;
                        r_rd_ack <= w_issue_nxt;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tag       = r_tag;
    assign tag_cplds = r_tag_cplds;
    assign tx_st     = r_tx_st;
    assign rd_ack    = r_rd_ack;
    assign busy      = r_busy;
    assign all_busy  = r_all_busy;

endmodule

// File: tb/tb_sfif_tag_alloc.sv
// Directed bench for sfif_tag_alloc with a small tracker model driving tag_available.
module tb_sfif_tag_alloc;

    logic       clk_125 = 1'b0;
    logic       rstn;
    logic       rd_req;
    logic [9:0] rd_len;
    logic       tx_rdy;
    logic       rx_st;
    logic       tag_available;
    logic [4:0] tag;
    logic [3:0] tag_cplds;
    logic       tx_st;
    logic       rd_ack;
    logic       busy;
    logic       all_busy;

    int total = 0;
    int bad   = 0;

    logic        rx_st_p_m;
    logic [31:0] busy_mask;

    sfif_tag_alloc #(.NUM_TAGS(32), .RCB_DW(16)) dut (
        .clk_125      (clk_125),
        .rstn         (rstn),
        .rd_req       (rd_req),
        .rd_len       (rd_len),
        .tx_rdy       (tx_rdy),
        .rx_st        (rx_st),
        .tag_available(tag_available),
        .tag          (tag),
        .tag_cplds    (tag_cplds),
        .tx_st        (tx_st),
        .rd_ack       (rd_ack),
        .busy         (busy),
        .all_busy     (all_busy)
    );

    always #4 clk_125 = ~clk_125;

    // Tracker model: refreshes availability of the presented tag unless rx_st_p is high
    always_ff @(posedge clk_125) begin
        if (!rstn) begin
            rx_st_p_m     <= 1'b0;
            tag_available <= 1'b0;
        end else begin
            rx_st_p_m <= rx_st;
            if (!rx_st_p_m) tag_available <= ~busy_mask[tag];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_125);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        rd_req = 1'b0;
        rx_st  = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Raise a request and return the cycle of the first tx_st (0 on timeout)
    task automatic do_req(input logic [9:0] len, output int cyc);
        rd_req = 1'b1;
        rd_len = len;
        cyc    = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (tx_st) begin
                cyc = c;
                break;
            end
        end
        rd_req = 1'b0;
    endtask

    int cyc;
    logic [9:0] lens  [5];
    logic [3:0] cplds [5];

    initial begin
        rstn      = 1'b0;
        rd_req    = 1'b0;
        rd_len    = 10'd0;
        tx_rdy    = 1'b1;
        rx_st     = 1'b0;
        busy_mask = 32'h0;
        lens  = '{10'd1, 10'd17, 10'd240, 10'd241, 10'd0};
        cplds = '{4'd1, 4'd2, 4'd15, 4'd15, 4'd15};

        // Reset values
        do_reset();
        rstn = 1'b0;
        tick();
        chk("rst_tag", 32'(tag), 0);
        chk("rst_cplds", 32'(tag_cplds), 0);
        chk("rst_tx_st", 32'(tx_st), 0);
        chk("rst_rd_ack", 32'(rd_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_all_busy", 32'(all_busy), 0);
        rstn = 1'b1;

        // Best-case issue and back-to-back tag advance
        do_req(10'd16, cyc);
        chk("first_cyc", 32'(cyc), 3);
        chk("first_tag", 32'(tag), 0);
        chk("first_cplds", 32'(tag_cplds), 1);
        chk("first_ack", 32'(rd_ack), 1);
        tick();
        chk("first_no_dbl", 32'(tx_st), 0);
        chk("first_idle", 32'(busy), 0);
        do_req(10'd16, cyc);
        chk("second_cyc", 32'(cyc), 3);
        chk("second_tag", 32'(tag), 1);
        tick();

        // Completion-count sweep
        for (int i = 0; i < 5; i++) begin
            do_req(lens[i], cyc);
            chk("len_cyc", 32'(cyc), 3);
            chk("len_cplds", 32'(tag_cplds), 32'(cplds[i]));
            chk("len_tag", 32'(tag), 32'(2 + i));
            tick();
        end

        // Tags 0..2 busy: tag 3 issued at cycle 9
        do_reset();
        busy_mask = 32'h7;
        do_req(10'd48, cyc);
        chk("skip_cyc", 32'(cyc), 9);
        chk("skip_tag", 32'(tag), 3);
        chk("skip_cplds", 32'(tag_cplds), 3);
        chk("skip_all_busy", 32'(all_busy), 0);
        tick();
        chk("skip_next_tag", 32'(tag), 4);
        busy_mask = 32'h0;

        // rx_st_p high in SETTLE and in ISSUE: each delays by one cycle
        do_reset();
        rd_req = 1'b1;
        rd_len = 10'd33;
        rx_st  = 1'b1;
        tick();
        rx_st = 1'b0;
        chk("rx_busy", 32'(busy), 1);
        tick();
        tick();
        chk("rx_c3_tx_st", 32'(tx_st), 0);
        rx_st = 1'b1;
        tick();
        chk("rx_c4_tx_st", 32'(tx_st), 0);
        rx_st = 1'b0;
        tick();
        chk("rx_c5_tx_st", 32'(tx_st), 1);
        chk("rx_c5_tag", 32'(tag), 0);
        chk("rx_c5_cplds", 32'(tag_cplds), 3);
        rd_req = 1'b0;
        tick();
        chk("rx_c6_tx_st", 32'(tx_st), 0);

        // All tags busy, then tag 5 freed at cycle 100; rd_req dropped mid-scan
        do_reset();
        busy_mask = 32'hFFFF_FFFF;
        rd_req = 1'b1;
        rd_len = 10'd64;
        cyc = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (c == 10) rd_req = 1'b0;
            if (c == 64) chk("ab_c64", 32'(all_busy), 0);
            if (c == 65) chk("ab_c65", 32'(all_busy), 1);
            if (c == 100) busy_mask = 32'hFFFF_FFDF;
            if (tx_st) begin
                cyc = c;
                break;
            end
        end
        chk("ab_cyc", 32'(cyc), 141);
        chk("ab_tag", 32'(tag), 5);
        chk("ab_cplds", 32'(tag_cplds), 4);
        chk("ab_still_set", 32'(all_busy), 1);
        chk("ab_ack", 32'(rd_ack), 1);
        tick();
        chk("ab_clear", 32'(all_busy), 0);
        chk("ab_next_tag", 32'(tag), 6);
        chk("ab_idle", 32'(busy), 0);
        busy_mask = 32'h0;

        // Reset while waiting in ISSUE with tx_rdy low
        tx_rdy = 1'b0;
        rd_req = 1'b1;
        rd_len = 10'd100;
        for (int c = 1; c <= 4; c++) tick();
        chk("rs_wait_tx_st", 32'(tx_st), 0);
        chk("rs_wait_busy", 32'(busy), 1);
        chk("rs_wait_tag", 32'(tag), 6);
        rstn   = 1'b0;
        tx_rdy = 1'b1;
        rd_req = 1'b0;
        tick();
        chk("rs_tx_st", 32'(tx_st), 0);
        chk("rs_ack", 32'(rd_ack), 0);
        chk("rs_tag", 32'(tag), 0);
        chk("rs_cplds", 32'(tag_cplds), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_all_busy", 32'(all_busy), 0);
        rstn = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("rs_dropped", 32'(tx_st | busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sfif_tag_alloc.md
# sfif_tag_alloc

Read-request tag allocator sitting directly upstream of the SFIF tag tracker (the block holding per-tag outstanding-completion counters). It accepts read requests from the DMA requester, scans tags round-robin until the tracker reports one free, computes how many completions the read will generate, and issues a one-cycle `tx_st` with `tag`/`tag_cplds` to both the TX engine and the tracker. It owns the tracker's `tag`, `tag_cplds` and `tx_st` inputs and observes `tag_available` and `rx_st`.

## Interface
- `NUM_TAGS`, 32: tags in rotation, power of two, 2..32; tags 0..NUM_TAGS-1 used.
- `RCB_DW`, 16: read completion boundary in DW (64 B); requester aligns read addresses to RCB.
- `clk_125` in 1: sole clock, all logic on rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `rd_req` in 1: read request, level; held with `rd_len` until `rd_ack`.
- `rd_len` in 10: read length in DW; 0 means 1024.
- `tx_rdy` in 1: TX engine can accept a start this cycle.
- `rx_st` in 1: RX start strobe, same signal the tracker receives.
- `tag_available` in 1: from tracker, 1 = currently presented tag has zero outstanding completions.
- `tag` out 5: tag presented to tracker and TX engine.
- `tag_cplds` out 4: expected completion count for the issued read.
- `tx_st` out 1: one-cycle issue strobe.
- `rd_ack` out 1: one-cycle pulse, coincident with `tx_st`.
- `busy` out 1: high in any state other than IDLE.
- `all_busy` out 1: high while a full sweep of NUM_TAGS tags has found none free; clears on issue.

## Operation
- Internal `rx_st_p` = `rx_st` registered one cycle (mirrors tracker). Tracker ignores `tx_st` and freezes `tag_available` in any cycle with `rx_st_p` high; this block honours both.
- States: IDLE, SETTLE, CHECK, ISSUE.
- IDLE: `tag` held. On `rd_req`: latch `rd_len`, register `tag_cplds`, clear sweep count -> SETTLE.
- SETTLE: `tag` stable. If `rx_st_p` low this cycle -> CHECK; else stay (tracker did not refresh).
- CHECK: `tag_available` now reflects current `tag`. If 1 -> ISSUE. If 0 -> `tag` <= (`tag`+1) mod NUM_TAGS, sweep count +1, -> SETTLE. Sweep count reaching NUM_TAGS sets `all_busy` and wraps to 0; scanning continues indefinitely.
- ISSUE: assert `tx_st` and `rd_ack` in the first cycle with `tx_rdy`=1 and `rx_st_p`=0; same edge: `tag` <= next tag, `all_busy` <= 0, -> IDLE. Otherwise wait in ISSUE, `tag`/`tag_cplds` stable.
- Completion count: L = (`rd_len`==0) ? 1024 : `rd_len`; N = ceil(L / RCB_DW); `tag_cplds` = min(N, 15). 11-bit intermediate arithmetic. Clamp is a requester contract violation; no flag.
- `rd_req` sampled only in IDLE; deassertion outside IDLE is ignored (request completes).
- Reset mid-operation: returns to IDLE, no `tx_st`, pending request dropped; requester must re-request.

## Timing
- Reset values: `tag`=0, `tag_cplds`=0, `tx_st`=0, `rd_ack`=0, `busy`=0, `all_busy`=0, state IDLE, `rx_st_p`=0.
- All outputs registered.
- Best case: `rd_req` seen in IDLE at cycle 0; SETTLE cycle 1; CHECK cycle 2; `tx_st` high cycle 3.
- Each rejected tag costs 2 cycles (SETTLE+CHECK) plus one per `rx_st_p` cycle in SETTLE.
- `tx_st` never high two consecutive cycles; never high while `rx_st_p` high.
- Back-to-back requests: next `tx_st` no earlier than 4 cycles after previous.

## Test plan
- Reset, all tags free, `rd_req` with `rd_len`=16, `tx_rdy`=1 -> `tx_st`/`rd_ack` at cycle 3, `tag`=0, `tag_cplds`=1; next request issues `tag`=1.
- `rd_len` sweep 1, 17, 240, 241, 0 -> `tag_cplds` = 1, 2, 15, 15, 15.
- Tracker model with tags 0..2 busy -> tags 0,1,2 rejected, `tx_st` with `tag`=3 at cycle 9.
- `rx_st` pulsed so `rx_st_p` high during SETTLE and during ISSUE with `tx_rdy`=1 -> SETTLE extended one cycle, `tx_st` delayed one cycle, tracker loads correct count.
- All 32 tags busy for 100 cycles, then tag 5 freed -> `all_busy` high after 64 cycles of scanning, issue on `tag`=5, `all_busy` clears same edge.
- `rstn` low during ISSUE with `tx_rdy`=0 -> no `tx_st`, all outputs at reset values next cycle, `tag`=0.
